// File: rtl/corePckg.sv
// Shared core types and constants: bus widths, arbiter state, memory access
// widths and the data-request / load-writeback records.
package corePckg;

    localparam int cXLEN           = 32;
    localparam int cRamDepth       = 1024;
    localparam int cRamAw          = $clog2(cRamDepth);
    localparam int cFetchStarveMax = 4;
    localparam int cStarveW        = $clog2(cFetchStarveMax + 1);

    typedef enum logic [1:0] {
        eArbIdle,
        eArbFetchWait,
        eArbLoadWait
    } tArbState;

    // Encodings follow funct3; stores only use the signed (bit 2 = 0) codes.
    typedef enum logic [2:0] {
        eLB  = 3'b000,
        eLH  = 3'b001,
        eLW  = 3'b010,
        eLBU = 3'b100,
        eLHU = 3'b101
    } tMemWidthEnum;

    typedef struct packed {
        logic             read;
        logic             write;
        logic [2:0]       opType;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] wData;
        logic [4:0]       rdAddr;
    } tMemOp;

    typedef struct packed {
        logic             dv;
        logic [4:0]       rdAddr;
        logic [cXLEN-1:0] data;
    } tRegOp;

    localparam tRegOp cRegOp = '{dv: 1'b0, rdAddr: 5'd0, data: '0};

    // Misaligned, conflicting or undefined requests are consumed without RAM access.
    function automatic logic memOpIllegal(input tMemOp op);
        logic illegal;
        illegal = op.read & op.write;
        case (op.opType)
            eLB, eLBU: illegal = illegal | (op.write & op.opType[2]);
            eLH, eLHU: illegal = illegal | op.addr[0] | (op.write & op.opType[2]);
            eLW:       illegal = illegal | (op.addr[1:0] != 2'b00);
            default:   illegal = 1'b1;
        endcase
        return illegal;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store lane enables and data replication on the way in,
// byte selection and sign/zero extension of load data on the way out.
module mem_lane_align
    import corePckg::*;
(
    input  logic [2:0]       storeOp,
    input  logic [1:0]       storeOff,
    input  logic [cXLEN-1:0] storeData,
    input  logic [2:0]       loadOp,
    input  logic [1:0]       loadOff,
    input  logic [cXLEN-1:0] ramRData,
    output logic [3:0]       laneWe,
    output logic [cXLEN-1:0] laneWData,
    output logic [cXLEN-1:0] loadData
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            // Bytes are replicated into every lane; the enables pick which ones land.
            assign laneWData[8*gi +: 8] = (storeOp[1:0] == 2'b00) ? storeData[7:0] :
                                          (storeOp[1:0] == 2'b01) ? storeData[8*(gi%2) +: 8] :
                                                                    storeData[8*gi +: 8];
            assign laneWe[gi] = (storeOp[1:0] == 2'b00) ? (storeOff == 2'(gi)) :
                                (storeOp[1:0] == 2'b01) ? (storeOff[1] == 1'(gi/2)) :
                                (storeOp[1:0] == 2'b10);
        end
    endgenerate

    logic [cXLEN-1:0] shifted;

    always_comb begin
        shifted  = ramRData >> {loadOff, 3'b000};
        loadData = ramRData;
        case (loadOp)
            eLB:     loadData = {{24{shifted[7]}}, shifted[7:0]};
            eLH:     loadData = {{16{shifted[15]}}, shifted[15:0]};
            eLBU:    loadData = {24'd0, shifted[7:0]};
            eLHU:    loadData = {16'd0, shifted[15:0]};
            default: loadData = ramRData;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store traffic,
// with data priority bounded by a fetch starvation counter.
module mem_port_arbiter
    import corePckg::*;
(
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iFetchReq,
    input  logic [cXLEN-1:0]  iFetchAddr,
    input  logic              iFlush,
    input  tMemOp             iMemOp,
    output logic              oFetchGnt,
    output logic              oFetchDv,
    output logic [cXLEN-1:0]  oFetchData,
    output logic              oMemBusy,
    output tRegOp             oLoadRes,
    output logic              oMemErr,
    output logic              oRamEn,
    output logic [3:0]        oRamWe,
    output logic [cRamAw-1:0] oRamAddr,
    output logic [cXLEN-1:0]  oRamWData,
    input  logic [cXLEN-1:0]  iRamRData
);

    tArbState          stateReg;
    logic [cStarveW-1:0] starveReg;
    logic              flushReg;
    logic [2:0]        ldOpReg;
    logic [1:0]        ldOffReg;
    logic [4:0]        ldRdReg;

    logic memReq, memIllegal, arbIdle, fetchWins;
    logic fetchGnt, dataGrant, storeGnt, loadGnt, errGnt;
    logic [3:0]       laneWe;
    logic [cXLEN-1:0] laneWData, loadData;
    logic             unusedAddrBits;

    assign unusedAddrBits = ^{iFetchAddr[cXLEN-1:cRamAw+2], iFetchAddr[1:0],
                              iMemOp.addr[cXLEN-1:cRamAw+2]};

    // Grant decisions are combinational so the RAM sees the address in the grant cycle.
    assign memReq     = iMemOp.read | iMemOp.write;
    assign memIllegal = memOpIllegal(iMemOp);
    assign arbIdle    = (stateReg == eArbIdle) & ~iRst;
    assign fetchWins  = iFetchReq & ((starveReg == cStarveW'(cFetchStarveMax)) | ~memReq);
    assign fetchGnt   = arbIdle & fetchWins;
    assign dataGrant  = arbIdle & memReq & ~fetchWins;
    assign storeGnt   = dataGrant & ~memIllegal & iMemOp.write;
    assign loadGnt    = dataGrant & ~memIllegal & iMemOp.read;
    assign errGnt     = dataGrant & memIllegal;

    assign oFetchGnt = fetchGnt;
    assign oMemBusy  = memReq & ~dataGrant;
    assign oMemErr   = errGnt;
    assign oRamEn    = fetchGnt | storeGnt | loadGnt;
    assign oRamWe    = storeGnt ? laneWe : 4'b0000;
    assign oRamAddr  = fetchGnt ? iFetchAddr[cRamAw+1:2] : iMemOp.addr[cRamAw+1:2];
    assign oRamWData = laneWData;

    mem_lane_align uLaneAlign (
        .storeOp   (iMemOp.opType),
        .storeOff  (iMemOp.addr[1:0]),
        .storeData (iMemOp.wData),
        .loadOp    (ldOpReg),
        .loadOff   (ldOffReg),
        .ramRData  (iRamRData),
        .laneWe    (laneWe),
        .laneWData (laneWData),
        .loadData  (loadData)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateReg   <= eArbIdle;
            starveReg  <= '0;
            flushReg   <= 1'b0;
            ldOpReg    <= 3'd0;
            ldOffReg   <= 2'd0;
            ldRdReg    <= 5'd0;
            oFetchDv   <= 1'b0;
            oFetchData <= '0;
            oLoadRes   <= cRegOp;
        end else begin
            oFetchDv <= 1'b0;
            oLoadRes <= cRegOp;

            if (fetchGnt)
                starveReg <= '0;
            else if (iFetchReq && starveReg != cStarveW'(cFetchStarveMax))
                starveReg <= starveReg + 1'b1;

            case (stateReg)
                eArbIdle: begin
                    if (fetchGnt) begin
                        stateReg <= eArbFetchWait;
                        flushReg <= iFlush;
                    end else if (loadGnt) begin
                        stateReg <= eArbLoadWait;
                        ldOpReg  <= iMemOp.opType;
                        ldOffReg <= iMemOp.addr[1:0];
                        ldRdReg  <= iMemOp.rdAddr;
                    end
                end
                eArbFetchWait: begin
                    // A flush in either the grant or this cycle kills the result.
                    oFetchData <= iRamRData;
                    oFetchDv   <= ~(flushReg | iFlush);
                    stateReg   <= eArbIdle;
                end
                eArbLoadWait: begin
                    oLoadRes <= '{dv: 1'b1, rdAddr: ldRdReg, data: loadData};
                    stateReg <= eArbIdle;
                end
                default: stateReg <= eArbIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;
    import corePckg::*;

    logic        iClk = 1'b0;
    logic        iRst, iFetchReq, iFlush;
    logic [31:0] iFetchAddr;
    tMemOp       iMemOp;
    logic        oFetchGnt, oFetchDv, oMemBusy, oMemErr, oRamEn;
    logic [31:0] oFetchData, oRamWData, iRamRData;
    tRegOp       oLoadRes;
    logic [3:0]  oRamWe;
    logic [9:0]  oRamAddr;

    always #5 iClk = ~iClk;

    mem_port_arbiter dut (
        .iClk(iClk), .iRst(iRst), .iFetchReq(iFetchReq), .iFetchAddr(iFetchAddr),
        .iFlush(iFlush), .iMemOp(iMemOp), .oFetchGnt(oFetchGnt), .oFetchDv(oFetchDv),
        .oFetchData(oFetchData), .oMemBusy(oMemBusy), .oLoadRes(oLoadRes), .oMemErr(oMemErr),
        .oRamEn(oRamEn), .oRamWe(oRamWe), .oRamAddr(oRamAddr), .oRamWData(oRamWData),
        .iRamRData(iRamRData)
    );

    logic [31:0] ram      [1024];
    logic [31:0] modelMem [1024];

    always @(posedge iClk) begin
        if (oRamEn) begin
            for (int b = 0; b < 4; b++)
                if (oRamWe[b]) ram[oRamAddr][8*b +: 8] <= oRamWData[8*b +: 8];
            iRamRData <= ram[oRamAddr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int accessBytes(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] loadValue(input logic [31:0] word, input logic [2:0] t,
                                              input logic [1:0] off);
        int n;
        logic [63:0] v, m;
        n = accessBytes(t);
        if (n == 4) return word;
        v = {32'd0, word} >> (8 * off);
        m = (64'd1 << (8 * n)) - 64'd1;
        v = v & m;
        if (!t[2] && v[8*n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    // ---------------- model + per-cycle compare ----------------
    int          freeAt = 0, starve = 0;
    bit          seenRst = 0, rstPrev = 0;
    bit          fetchPend = 0, fetchFlushed = 0, loadPend = 0;
    int          fetchDue = 0, loadDue = 0;
    logic [31:0] fetchExp, loadExp;
    logic [4:0]  loadRdExp;

    always @(negedge iClk) begin
        bit memReq, illegal, idle, fGnt, dGnt, isStore, isLoad;
        int n, off;
        logic [3:0]  weExp;
        logic [31:0] wMask, wExp;
        memReq  = iMemOp.read | iMemOp.write;
        n       = accessBytes(iMemOp.opType);
        off     = int'(iMemOp.addr[1:0]);
        illegal = (iMemOp.read && iMemOp.write) || n == 0 || (iMemOp.write && iMemOp.opType[2])
                  || (n != 0 && (off % n) != 0);
        idle    = !iRst && cyc >= freeAt;
        fGnt    = idle && iFetchReq && (starve == cFetchStarveMax || !memReq);
        dGnt    = idle && memReq && !fGnt;
        isStore = dGnt && !illegal && iMemOp.write;
        isLoad  = dGnt && !illegal && iMemOp.read;
        weExp   = isStore ? 4'(((1 << n) - 1) << off) : 4'd0;

        check("fetchGnt", 64'(oFetchGnt), 64'(fGnt));
        check("memBusy",  64'(oMemBusy),  64'(memReq && !dGnt));
        check("memErr",   64'(oMemErr),   64'(dGnt && illegal));
        check("ramEn",    64'(oRamEn),    64'(fGnt || isStore || isLoad));
        check("ramWe",    64'(oRamWe),    64'(weExp));
        if (fGnt) check("ramAddrF", 64'(oRamAddr), 64'(iFetchAddr[11:2]));
        if (isStore || isLoad) check("ramAddrD", 64'(oRamAddr), 64'(iMemOp.addr[11:2]));
        if (isStore) begin
            wMask = '0; wExp = '0;
            for (int k = 0; k < n; k++) begin
                wMask[8*(off+k) +: 8] = 8'hFF;
                wExp[8*(off+k) +: 8]  = iMemOp.wData[8*k +: 8];
            end
            check("ramWData", 64'(oRamWData & wMask), 64'(wExp));
        end

        if (seenRst) begin
            check("fetchDv", 64'(oFetchDv), 64'(fetchPend && fetchDue == cyc && !fetchFlushed));
            if (fetchPend && fetchDue == cyc && !fetchFlushed)
                check("fetchData", 64'(oFetchData), 64'(fetchExp));
            check("loadDv", 64'(oLoadRes.dv), 64'(loadPend && loadDue == cyc));
            if (loadPend && loadDue == cyc) begin
                check("loadRd",   64'(oLoadRes.rdAddr), 64'(loadRdExp));
                check("loadData", 64'(oLoadRes.data),   64'(loadExp));
            end
            if (rstPrev) begin
                check("rstFetchData", 64'(oFetchData), 64'd0);
                check("rstLoadRes",   64'(oLoadRes),   64'd0);
            end
        end

        if (fetchPend && cyc == fetchDue - 1 && iFlush) fetchFlushed = 1;
        if (fetchPend && cyc >= fetchDue) fetchPend = 0;
        if (loadPend && cyc >= loadDue) loadPend = 0;
        if (iRst) begin
            fetchPend = 0; loadPend = 0; starve = 0; freeAt = cyc + 1;
        end else begin
            if (fGnt) begin
                fetchPend = 1; fetchDue = cyc + 2; fetchFlushed = iFlush;
                fetchExp = modelMem[iFetchAddr[11:2]]; freeAt = cyc + 2;
            end
            if (isLoad) begin
                loadPend = 1; loadDue = cyc + 2; loadRdExp = iMemOp.rdAddr; freeAt = cyc + 2;
                loadExp = loadValue(modelMem[iMemOp.addr[11:2]], iMemOp.opType, iMemOp.addr[1:0]);
            end
            if (isStore)
                for (int k = 0; k < n; k++)
                    modelMem[iMemOp.addr[11:2]][8*(off+k) +: 8] = iMemOp.wData[8*k +: 8];
            if (fGnt) starve = 0;
            else if (iFetchReq && starve < cFetchStarveMax) starve++;
        end
        if (iRst) seenRst = 1;
        rstPrev = iRst;
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic memOp(input bit rd, input bit wr, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rdA,
                         output bit errSeen, output bit enSeen, output logic [3:0] weSeen);
        bit done;
        done = 0;
        iMemOp = '{read: rd, write: wr, opType: op, addr: addr, wData: data, rdAddr: rdA};
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge iClk);
            if (!oMemBusy) begin
                done = 1; errSeen = oMemErr; enSeen = oRamEn; weSeen = oRamWe;
            end
            step();
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL memOpTimeout addr=%h got=busy want=granted", addr);
        end
        $display("memop rd=%0d wr=%0d type=%0d addr=%h data=%h err=%0d", rd, wr, op, addr, data, errSeen);
        iMemOp = '0;
    endtask

    task automatic fetch(input logic [31:0] addr, input bit flushAtGnt);
        bit done;
        done = 0;
        iFetchReq = 1; iFetchAddr = addr; iFlush = flushAtGnt;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge iClk);
            if (oFetchGnt) done = 1;
            step();
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL fetchTimeout addr=%h got=no-grant want=grant", addr);
        end
        $display("fetch addr=%h flush=%0d", addr, flushAtGnt);
        iFetchReq = 0; iFlush = 0;
    endtask

    bit          e, en;
    logic [3:0]  we;
    int          gntAt, nStores, dvCount;
    bit          granted;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]      = 32'hA5000000 ^ (i * 32'h00010203);
            modelMem[i] = 32'hA5000000 ^ (i * 32'h00010203);
        end
        iRst = 1; iFetchReq = 0; iFetchAddr = '0; iFlush = 0; iMemOp = '0;
        repeat (2) step();
        @(negedge iClk);
        check("rstLoadResLit", 64'(oLoadRes), 64'd0);
        check("rstDvLit",      64'(oFetchDv), 64'd0);
        step();
        iRst = 0;
        step();

        // SW 0x10, then LB 0x13 and LHU 0x12, then misaligned LH 0x11
        memOp(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, e, en, we);
        check("swWeLit", 64'(we), 64'hF);
        memOp(1, 0, 3'b000, 32'h13, 0, 5'd3, e, en, we);
        step();
        @(negedge iClk);
        check("lbDvLit",   64'(oLoadRes.dv),   64'd1);
        check("lbDataLit", 64'(oLoadRes.data), 64'hFFFFFFDE);
        step();
        memOp(1, 0, 3'b101, 32'h12, 0, 5'd4, e, en, we);
        step();
        @(negedge iClk);
        check("lhuDataLit", 64'(oLoadRes.data), 64'h0000DEAD);
        step();
        memOp(1, 0, 3'b001, 32'h11, 0, 5'd5, e, en, we);
        check("lhErrLit", 64'(e),  64'd1);
        check("lhEnLit",  64'(en), 64'd0);

        // Mixed widths, aliasing above bit 11, and illegal requests
        memOp(0, 1, 3'b000, 32'h21, 32'h00000077, 0, e, en, we);
        check("sbWeLit", 64'(we), 64'h2);
        memOp(1, 0, 3'b100, 32'h21, 0, 5'd6, e, en, we);
        memOp(0, 1, 3'b001, 32'h22, 32'h00008001, 0, e, en, we);
        memOp(1, 0, 3'b001, 32'h22, 0, 5'd7, e, en, we);
        memOp(0, 1, 3'b010, 32'hF030, 32'h12345678, 0, e, en, we);
        memOp(1, 0, 3'b010, 32'h30, 0, 5'd8, e, en, we);
        memOp(1, 1, 3'b010, 32'h40, 0, 5'd9, e, en, we);
        memOp(1, 0, 3'b011, 32'h40, 0, 5'd9, e, en, we);
        memOp(0, 1, 3'b100, 32'h40, 0, 0, e, en, we);
        memOp(1, 0, 3'b010, 32'h42, 0, 5'd9, e, en, we);
        check("lwMisErrLit", 64'(e), 64'd1);
        repeat (3) step();

        // Continuous stores with a fetch pending: fetch wins on the 5th cycle
        iFetchReq = 1; iFetchAddr = 32'h20; gntAt = -1; nStores = 0;
        for (int c = 1; c <= 12; c++) begin
            iMemOp = '{read: 0, write: 1, opType: 3'b010, addr: 32'h100 + 32'(4 * nStores),
                       wData: 32'hC0DE0000 + 32'(nStores), rdAddr: 0};
            @(negedge iClk);
            if (oFetchGnt) gntAt = c;
            granted = !oMemBusy;
            step();
            if (gntAt == c) iFetchReq = 0;
            if (granted) nStores++;
        end
        iMemOp = '0;
        $display("starve run fetchGnt cycle=%0d stores=%0d", gntAt, nStores);
        check("starveGntLit", 64'(gntAt),   64'd5);
        check("starveStores", 64'(nStores), 64'd10);
        repeat (3) step();

        // Flush in the wait cycle, then a clean fetch of the stored word
        fetch(32'h10, 0);
        iFlush = 1;
        dvCount = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            if (oFetchDv) dvCount++;
            step();
            iFlush = 0;
        end
        check("flushNoDvLit", 64'(dvCount), 64'd0);
        fetch(32'h10, 0);
        step();
        @(negedge iClk);
        check("fetchDvLit",   64'(oFetchDv),   64'd1);
        check("fetchDataLit", 64'(oFetchData), 64'hDEADBEEF);
        step();
        fetch(32'h24, 1);
        repeat (3) step();

        // Reset while in the load wait state
        memOp(1, 0, 3'b010, 32'h10, 0, 5'd11, e, en, we);
        iRst = 1;
        step();
        iRst = 0;
        @(negedge iClk);
        check("rstMidLoadRes", 64'(oLoadRes),  64'd0);
        check("rstMidEnWe",    64'({oRamEn, oRamWe, oFetchGnt, oMemErr, oFetchDv}), 64'd0);
        dvCount = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge iClk);
            if (oLoadRes.dv) dvCount++;
        end
        check("rstNoDvLit", 64'(dvCount), 64'd0);
        memOp(1, 0, 3'b010, 32'h10, 0, 5'd12, e, en, we);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL globalTimeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
